// File: rtl/strassen_operand_gen.sv
`default_nettype none
// ============================================================================
// Module      : strassen_operand_gen
// Description : Operand-generation stage of the Strassen 2x2 block multiplier.
//               Captures one A/B quadrant block, then emits the seven
//               pre-added (OpA, OpB) operand pairs M1..M7 under a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module strassen_operand_gen #(
  parameter int width = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*width-1:0]      A_in,
  input  logic [4*width-1:0]      B_in,
  input  logic                    In_valid,
  output logic                    In_ready,
  output logic signed [width:0]   OpA,
  output logic signed [width:0]   OpB,
  output logic [2:0]              Idx,
  output logic                    Last,
  output logic                    Out_valid,
  input  logic                    Out_ready
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  localparam logic [2:0] c_LAST_IDX = 3'd6;

  state_t                  state_q, state_d;
  logic [4*width-1:0]      a_q, a_d;
  logic [4*width-1:0]      b_q, b_d;
  logic signed [width:0]   opa_q, opa_d;
  logic signed [width:0]   opb_q, opb_d;
  logic [2:0]              idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;

  logic                    w_idle;
  logic                    w_accept;
  logic                    w_advance;
  logic [4*width-1:0]      w_src_a;
  logic [4*width-1:0]      w_src_b;
  logic [2:0]              w_pidx;
  logic signed [width-1:0] w_a11, w_a12, w_a21, w_a22;
  logic signed [width-1:0] w_b11, w_b12, w_b21, w_b22;
  logic signed [width:0]   w_pair_a, w_pair_b;

  // Sign-extend one element by a single bit so sums and differences never overflow.
  function automatic logic signed [width:0] sext(input logic signed [width-1:0] v);
    sext = {v[width-1], v};
  endfunction

  assign w_idle    = (state_q == S_IDLE);
  // Held low during reset so upstream never sees a handshake that will be discarded.
  assign In_ready  = Rst && w_idle;
  assign w_accept  = In_valid && w_idle;
  assign w_advance = (state_q == S_EMIT) && valid_q && Out_ready;

  // On accept the M1 pair is built straight from the live inputs; afterwards
  // every pair comes from the captured copies, so later input changes are ignored.
  assign w_src_a = w_idle ? A_in : a_q;
  assign w_src_b = w_idle ? B_in : b_q;
  assign w_pidx  = w_idle ? 3'd0 : (idx_q + 3'd1);

  assign w_a11 = w_src_a[  width-1:0      ];
  assign w_a12 = w_src_a[2*width-1:  width];
  assign w_a21 = w_src_a[3*width-1:2*width];
  assign w_a22 = w_src_a[4*width-1:3*width];
  assign w_b11 = w_src_b[  width-1:0      ];
  assign w_b12 = w_src_b[2*width-1:  width];
  assign w_b21 = w_src_b[3*width-1:2*width];
  assign w_b22 = w_src_b[4*width-1:3*width];

  // Strassen operand table: pre-added left/right operands for product w_pidx.
  always_comb begin
    w_pair_a = '0;
    w_pair_b = '0;
    case (w_pidx)
      3'd0: begin
        w_pair_a = sext(w_a11) + sext(w_a22);
        w_pair_b = sext(w_b11) + sext(w_b22);
      end
      3'd1: begin
        w_pair_a = sext(w_a21) + sext(w_a22);
        w_pair_b = sext(w_b11);
      end
      3'd2: begin
        w_pair_a = sext(w_a11);
        w_pair_b = sext(w_b12) - sext(w_b22);
      end
      3'd3: begin
        w_pair_a = sext(w_a22);
        w_pair_b = sext(w_b21) - sext(w_b11);
      end
      3'd4: begin
        w_pair_a = sext(w_a11) + sext(w_a12);
        w_pair_b = sext(w_b22);
      end
      3'd5: begin
        w_pair_a = sext(w_a21) - sext(w_a11);
        w_pair_b = sext(w_b11) + sext(w_b12);
      end
      3'd6: begin
        w_pair_a = sext(w_a12) - sext(w_a22);
        w_pair_b = sext(w_b21) + sext(w_b22);
      end
      default: begin
        w_pair_a = '0;
        w_pair_b = '0;
      end
    endcase
  end

  // Next-state logic: everything holds unless a block is accepted or a beat is taken.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          a_d     = A_in;
          b_d     = B_in;
          opa_d   = w_pair_a;
          opb_d   = w_pair_b;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_advance) begin
          if (idx_q == c_LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + 3'd1;
            opa_d  = w_pair_a;
            opb_d  = w_pair_b;
            last_d = (idx_q == (c_LAST_IDX - 3'd1));
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign OpA       = opa_q;
  assign OpB       = opb_q;
  assign Idx       = idx_q;
  assign Last      = last_q;
  assign Out_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/strassen_operand_gen.md
# strassen_operand_gen

Operand-generation stage for the Strassen 2x2 block multiplier. It accepts one set of A and B quadrant elements through a valid/ready handshake. It then sequences the seven Strassen products M1..M7, emitting one registered (OpA, OpB) pre-added operand pair per accepted beat. Its outputs feed the operand register banks directly downstream, whose enable is driven by `Out_valid & Out_ready`.

## Interface
- `width`, default 32: bit width of each signed input element. Operand outputs are `width+1` bits.
- `Clk`  input  1  system clock; all state updates on the rising edge.
- `Rst`  input  1  synchronous reset, active-low.
- `A_in`  input  4*width  signed A quadrants, packed as follows:
  - `A11` = `[width-1:0]`
  - `A12` = `[2w-1:w]`
  - `A21` = `[3w-1:2w]`
  - `A22` = `[4w-1:3w]`
- `B_in`  input  4*width  signed B quadrants, same packing as `A_in`.
- `In_valid`  input  1  `A_in`/`B_in` hold a valid block.
- `In_ready`  output  1  block can be accepted.
- `OpA`  output  width+1  signed left operand of the current product.
- `OpB`  output  width+1  signed right operand of the current product.
- `Idx`  output  3  product index, 0..6 (M1..M7).
- `Last`  output  1  high while `Idx` == 6 and `Out_valid` is high.
- `Out_valid`  output  1  `OpA`/`OpB`/`Idx` are valid.
- `Out_ready`  input  1  downstream accepts the current pair.

## Operation
- States are IDLE and EMIT.
- IDLE:
  - `In_ready` = 1.
  - On `In_valid & In_ready`: capture `A_in`/`B_in` into internal registers, load the M1 pair into `OpA`/`OpB`, set `Idx`=0, set `Out_valid`=1, and go to EMIT.
- EMIT:
  - `In_ready` = 0.
  - On `Out_valid & Out_ready` with `Idx`<6: increment `Idx` and register the next pair.
  - On `Out_valid & Out_ready` with `Idx`==6: set `Out_valid`=0, `Last`=0, and return to IDLE.
  - While `Out_ready`=0: `OpA`, `OpB`, `Idx` and `Last` hold exactly (no change of any bit).
- Operand pairs; all arithmetic is two's complement, each element is sign-extended to width+1 before the add/subtract, and there is no saturation:
  - M1: (A11+A22), (B11+B22)
  - M2: (A21+A22), B11
  - M3: A11, (B12−B22)
  - M4: A22, (B21−B11)
  - M5: (A11+A12), B22
  - M6: (A21−A11), (B11+B12)
  - M7: (A12−A22), (B21+B22)
- Single-element operands are sign-extended to width+1.
- Input changes on `A_in`/`B_in` after capture have no effect until the next accept.

## Timing
- Reset (`Rst`=0 at a rising edge) values:
  - state = IDLE
  - `Out_valid` = 0, `Last` = 0, `Idx` = 0
  - `OpA` = 0, `OpB` = 0
  - internal capture registers = 0
- `In_ready` = 0 while `Rst`=0. Otherwise `In_ready` = (state==IDLE), decoded combinationally from the state register.
- Reset mid-block: the sequence is abandoned; there are no further `Out_valid` beats until a new accept.
- Latency: a block accepted at edge k has M1 valid in the cycle after edge k.
- With `Out_ready` held at 1, M1..M7 appear on 7 consecutive cycles. `Out_valid` falls after edge k+7, and a new block can be accepted at edge k+8 at the earliest (1 block per 8 cycles).
- Simultaneous `In_valid` in EMIT: ignored; the upstream holds it until `In_ready`.
- `Out_ready` may toggle arbitrarily. Each `Idx` value is transferred exactly once, in order 0..6.
- `Idx` never wraps past 6; the EMIT→IDLE transition occurs only on the accepted `Idx`==6 beat.

## Test plan
- **Basic sequence.** `width`=8, A11..A22 = 3, 5, −2, 7 and B11..B22 = 1, 4, −6, 2, `Out_ready`=1. Required (`OpA`, `OpB`) for `Idx` 0..6, on consecutive cycles, with `Last` only on (−2, −4):
  - `Idx` 0: (10, 3)
  - `Idx` 1: (5, 1)
  - `Idx` 2: (3, 2)
  - `Idx` 3: (7, −7)
  - `Idx` 4: (8, 2)
  - `Idx` 5: (−5, 5)
  - `Idx` 6: (−2, −4)
- **Width growth.** `width`=8, A11=A22=127, B11=B22=−128. M1 requires `OpA`=9'h0FE (254) and `OpB`=9'h100 (−256).
- **Backpressure.** Same stimulus as the basic sequence, with `Out_ready` low for 3 cycles at `Idx`=2. Required: `OpA`=3, `OpB`=2, `Idx`=2 stable for all 4 cycles; M4 follows; no beat is dropped or duplicated.
- **Accept gating.** `In_valid` held high throughout with a second block presented during EMIT. Required: `In_ready`=0 for 7 cycles; the second block is accepted only in IDLE, and its M1 appears 1 cycle later.
- **Reset mid-operation.** `Rst`=0 for one edge while `Idx`=3. Required on the next cycle: `Out_valid`=0, `Idx`=0, `OpA`=`OpB`=0, `Last`=0. `In_ready` returns to 1 once `Rst`=1.
- **Input isolation.** Change `A_in`/`B_in` every cycle after an accept. Required: all 7 pairs reflect the captured values only.
